// File: rtl/mem_fetch_unit_pkg.sv
// Shared definitions for the memory fetch unit: FSM states, timeout default
// and instruction field positions used by both this unit and the decoder.
package mem_fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

  localparam int TIMEOUT_DEFAULT = 15;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

endpackage

// File: rtl/mem_fetch_unit_if.sv
// Memory request/response bus between the fetch unit (master) and memory (slave).
interface mem_fetch_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_fetch_unit_wait.sv
// mem_wait_timer: counts BUSY cycles without an acknowledge and flags the
// cycle in which the count reaches TIMEOUT.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);
  localparam logic [8:0] LIMIT = 9'(TIMEOUT);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the wait cycle that brings the count up to TIMEOUT.
  assign expired = count && (({1'b0, cnt_q} + 9'd1) == LIMIT);

endmodule

// File: rtl/mem_fetch_unit.sv
// Memory fetch unit: captures one memory access per controller request,
// drives the memory bus until ack or timeout, and holds the IR and MDR.
module mem_fetch_unit
  import mem_fetch_unit_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    access,
  input  logic                    iord,
  input  logic                    memwrite,
  input  logic                    irwrite,
  input  logic [31:0]             pc,
  input  logic [31:0]             aluout,
  input  logic [31:0]             writedata,
  mem_fetch_unit_if.master        bus,
  output logic                    stall,
  output logic [31:0]             instr,
  output logic [5:0]              op,
  output logic [5:0]              funct,
  output logic [4:0]              rs,
  output logic [4:0]              rt,
  output logic [4:0]              rd,
  output logic [15:0]             imm,
  output logic [31:0]             mdr,
  output logic                    timeout_err
);

  fetch_state_e state_q;
  logic         req_q;
  logic         we_q;
  logic [31:0]  addr_q;
  logic [31:0]  wdata_q;
  logic         ircap_q;
  logic [31:0]  instr_q;
  logic [31:0]  mdr_q;
  logic         err_q;

  logic timer_clear;
  logic timer_count;
  logic timer_expired;

  assign timer_clear = (state_q == IDLE) && access;
  assign timer_count = (state_q == BUSY) && !bus.mem_ack;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .count   (timer_count),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ircap_q <= 1'b0;
      instr_q <= '0;
      mdr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (access) begin
            addr_q  <= iord ? aluout : pc;
            we_q    <= memwrite;
            wdata_q <= writedata;
            ircap_q <= irwrite && !memwrite;
            req_q   <= 1'b1;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          // An ack wins over expiry in the same cycle.
          if (bus.mem_ack) begin
            if (!we_q) mdr_q <= bus.mem_rdata;
            if (ircap_q) instr_q <= bus.mem_rdata;
            req_q   <= 1'b0;
            state_q <= DONE;
          end else if (timer_expired) begin
            err_q   <= 1'b1;
            req_q   <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign stall = ((state_q == IDLE) && access) || (state_q == BUSY);

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign instr       = instr_q;
  assign mdr         = mdr_q;
  assign timeout_err = err_q;

  assign op    = instr_q[OP_MSB:OP_LSB];
  assign funct = instr_q[FUNCT_MSB:FUNCT_LSB];
  assign rs    = instr_q[RS_MSB:RS_LSB];
  assign rt    = instr_q[RT_MSB:RT_LSB];
  assign rd    = instr_q[RD_MSB:RD_LSB];
  assign imm   = instr_q[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_mem_fetch_unit.sv
// Self-checking bench for mem_fetch_unit: directed vector table, reset and
// back-to-back sequences, then randomized transactions against a
// transaction-level model.
module tb_mem_fetch_unit;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        access;
  logic        iord;
  logic        memwrite;
  logic        irwrite;
  logic [31:0] pc;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic        stall;
  logic [31:0] instr;
  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;
  logic [31:0] mdr;
  logic        timeout_err;

  mem_fetch_unit_if bus ();

  mem_fetch_unit #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .access      (access),
    .iord        (iord),
    .memwrite    (memwrite),
    .irwrite     (irwrite),
    .pc          (pc),
    .aluout      (aluout),
    .writedata   (writedata),
    .bus         (bus),
    .stall       (stall),
    .instr       (instr),
    .op          (op),
    .funct       (funct),
    .rs          (rs),
    .rt          (rt),
    .rd          (rd),
    .imm         (imm),
    .mdr         (mdr),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Transaction-level model state.
  logic [31:0] exp_instr;
  logic [31:0] exp_mdr;
  logic        exp_err;

  typedef struct {
    logic        iord;
    logic        mw;
    logic        irw;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] rdat;
    int          delay;
    logic [31:0] exp_addr;
    logic [31:0] exp_mdr;
    logic [31:0] exp_instr;
    logic        exp_err;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_fields();
    logic [31:0] e;
    e = exp_instr;
    check("instr", instr, e);
    check("op", 32'(op), 32'(e[31:26]));
    check("rs", 32'(rs), 32'(e[25:21]));
    check("rt", 32'(rt), 32'(e[20:16]));
    check("rd", 32'(rd), 32'(e[15:11]));
    check("funct", 32'(funct), 32'(e[5:0]));
    check("imm", 32'(imm), 32'(e[15:0]));
  endtask

  // One transaction: IDLE request cycle, BUSY cycles until ack (after `delay`
  // wait cycles) or TO wait cycles, then the DONE cycle.
  task automatic run_txn(input logic iord_v, input logic mw, input logic irw,
                         input logic [31:0] pc_v, input logic [31:0] alu_v,
                         input logic [31:0] wd_v, input logic [31:0] rd_v,
                         input int delay, input bit hold,
                         output logic [31:0] seen_addr);
    logic [31:0] ea;
    bit          timed_out;
    ea        = iord_v ? alu_v : pc_v;
    timed_out = (delay >= TO);
    seen_addr = 'x;

    @(negedge clk);
    access = 1'b1; iord = iord_v; memwrite = mw; irwrite = irw;
    pc = pc_v; aluout = alu_v; writedata = wd_v;
    bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
    #1;
    check("idle_stall", 32'(stall), 32'd1);
    check("idle_req", 32'(bus.mem_req), 32'd0);

    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      access = hold; iord = 1'($urandom_range(0, 1)); memwrite = 1'($urandom_range(0, 1));
      irwrite = 1'($urandom_range(0, 1));
      pc = $urandom; aluout = $urandom; writedata = $urandom;
      bus.mem_ack   = (k == delay);
      bus.mem_rdata = (k == delay) ? rd_v : $urandom;
      #1;
      if (k == 0) seen_addr = bus.mem_addr;
      check("busy_req", 32'(bus.mem_req), 32'd1);
      check("busy_addr", bus.mem_addr, ea);
      check("busy_we", 32'(bus.mem_we), 32'(mw));
      check("busy_wdata", bus.mem_wdata, wd_v);
      check("busy_stall", 32'(stall), 32'd1);
      if (k == delay) break;
    end

    if (timed_out) begin
      exp_err = 1'b1;
    end else begin
      if (!mw) exp_mdr = rd_v;
      if (irw && !mw) exp_instr = rd_v;
    end

    @(negedge clk);
    access = hold; bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
    #1;
    check("done_stall", 32'(stall), 32'd0);
    check("done_req", 32'(bus.mem_req), 32'd0);
    check("mdr", mdr, exp_mdr);
    check("timeout_err", 32'(timeout_err), 32'(exp_err));
    check_fields();
  endtask

  task automatic idle_cycle(input bit stray_ack);
    @(negedge clk);
    access = 1'b0; bus.mem_ack = stray_ack; bus.mem_rdata = $urandom;
    #1;
    check("gap_req", 32'(bus.mem_req), 32'd0);
    check("gap_stall", 32'(stall), 32'd0);
    check("gap_mdr", mdr, exp_mdr);
    check("gap_instr", instr, exp_instr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a1;
    logic [31:0] a2;

    //            iord mw irw pc        alu       wd            rdata         dly addr      mdr           instr         err
    tbl[0] = '{1'b0, 1'b0, 1'b1, 32'h40,  32'h999,  32'h0,        32'h8C43_0004, 0, 32'h40,   32'h8C43_0004, 32'h8C43_0004, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 32'h44,  32'h1004, 32'h0,        32'hDEAD_BEEF, 3, 32'h1004, 32'hDEAD_BEEF, 32'h8C43_0004, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h48,  32'h20,   32'h1234_5678, 32'hFFFF_0000, 1, 32'h20,   32'hDEAD_BEEF, 32'h8C43_0004, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h80,  32'h24,   32'hA5A5_A5A5, 32'h1111_1111, 2, 32'h80,   32'hDEAD_BEEF, 32'h8C43_0004, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h100, 32'h28,   32'h0,        32'h014B_4820, 2, 32'h100,  32'h014B_4820, 32'h014B_4820, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 32'h104, 32'h2000, 32'h0,        32'h7777_7777, 99, 32'h2000, 32'h014B_4820, 32'h014B_4820, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 32'h108, 32'h3000, 32'h0,        32'h0BAD_F00D, 0, 32'h3000, 32'h0BAD_F00D, 32'h014B_4820, 1'b1};

    reset = 1'b1; access = 1'b0; iord = 1'b0; memwrite = 1'b0; irwrite = 1'b0;
    pc = '0; aluout = '0; writedata = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    exp_instr = '0; exp_mdr = '0; exp_err = 1'b0;

    @(negedge clk);
    #1;
    check("rst_req", 32'(bus.mem_req), 32'd0);
    check("rst_addr", bus.mem_addr, 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);
    check_fields();
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i].iord, tbl[i].mw, tbl[i].irw, tbl[i].pc, tbl[i].alu, tbl[i].wd,
              tbl[i].rdat, tbl[i].delay, 1'b0, a1);
      check("tbl_addr", a1, tbl[i].exp_addr);
      check("tbl_mdr", mdr, tbl[i].exp_mdr);
      check("tbl_instr", instr, tbl[i].exp_instr);
      check("tbl_err", 32'(timeout_err), 32'(tbl[i].exp_err));
      $display("vector %0d: addr=%h mdr=%h instr=%h err=%0b", i, a1, mdr, instr, timeout_err);
      idle_cycle(1'b1);
    end

    // Reset in the 2nd BUSY cycle of a load, then a stray ack.
    @(negedge clk);
    access = 1'b1; iord = 1'b1; memwrite = 1'b0; irwrite = 1'b0;
    aluout = 32'h5000; writedata = 32'hFFFF_FFFF; bus.mem_ack = 1'b0;
    @(negedge clk);
    access = 1'b0;
    #1 check("rst_busy1_req", 32'(bus.mem_req), 32'd1);
    @(negedge clk);
    #1 check("rst_busy2_req", 32'(bus.mem_req), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_req", 32'(bus.mem_req), 32'd0);
    check("rst_mid_we", 32'(bus.mem_we), 32'd0);
    check("rst_mid_addr", bus.mem_addr, 32'd0);
    check("rst_mid_wdata", bus.mem_wdata, 32'd0);
    check("rst_mid_mdr", mdr, 32'd0);
    check("rst_mid_err", 32'(timeout_err), 32'd0);
    check("rst_mid_stall", 32'(stall), 32'd0);
    exp_instr = '0; exp_mdr = '0; exp_err = 1'b0;
    check_fields();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_BABE;
    #1 check("stray_req", 32'(bus.mem_req), 32'd0);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    check("stray_mdr", mdr, 32'd0);
    check("stray_req2", 32'(bus.mem_req), 32'd0);
    $display("reset sequence: req=%0b mdr=%h instr=%h", bus.mem_req, mdr, instr);

    // Access held high across DONE: the next IDLE starts exactly one new request.
    run_txn(1'b0, 1'b0, 1'b1, 32'h200, 32'h0, 32'h0, 32'h2222_2222, 1, 1'b1, a1);
    run_txn(1'b0, 1'b0, 1'b1, 32'h204, 32'h0, 32'h0, 32'h3333_3333, 0, 1'b0, a2);
    check("b2b_addr1", a1, 32'h200);
    check("b2b_addr2", a2, 32'h204);
    $display("back-to-back: addr1=%h addr2=%h instr=%h", a1, a2, instr);

    for (int n = 0; n < 40; n++) begin
      int          gap;
      int          dly;
      logic        r_iord;
      logic        r_mw;
      logic        r_irw;
      logic [31:0] r_pc;
      logic [31:0] r_alu;
      logic [31:0] r_wd;
      logic [31:0] r_rd;
      bit          r_hold;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) idle_cycle(1'($urandom_range(0, 1)));
      r_iord = 1'($urandom_range(0, 1));
      r_mw   = 1'($urandom_range(0, 1));
      r_irw  = 1'($urandom_range(0, 1));
      r_pc   = $urandom; r_alu = $urandom; r_wd = $urandom; r_rd = $urandom;
      dly    = $urandom_range(0, TO + 1);
      r_hold = ($urandom_range(0, 3) == 0);
      run_txn(r_iord, r_mw, r_irw, r_pc, r_alu, r_wd, r_rd, dly, r_hold, a1);
      check("rnd_addr", a1, r_iord ? r_alu : r_pc);
      $display("random %0d: iord=%0b we=%0b ir=%0b dly=%0d addr=%h mdr=%h instr=%h err=%0b",
               n, r_iord, r_mw, r_irw, dly, a1, mdr, instr, timeout_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_fetch_unit.md
MEM_FETCH_UNIT -- requirements
Module: mem_fetch_unit

Interface
REQ-001 Parameter TIMEOUT SHALL default to 15; it is the number of BUSY cycles without mem_ack before abort. Legal range is 1..255.
REQ-002 Port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port access, input, 1: the controller state needs a memory transaction.
REQ-005 Port iord, input, 1: address select; 0 selects pc, 1 selects aluout.
REQ-006 Port memwrite, input, 1: the transaction is a store.
REQ-007 Port irwrite, input, 1: read data is an instruction fetch.
REQ-008 Ports pc, aluout, writedata, input, 32 each: address sources and store data.
REQ-009 Ports mem_req (1), mem_we (1), mem_addr (32), mem_wdata (32), output: the memory request bus.
REQ-010 Port mem_ack, input, 1: memory completion strobe. Port mem_rdata, input, 32: read data, valid only with mem_ack.
REQ-011 Port stall, output, 1: holds the controller FSM in its current state.
REQ-012 Port instr, output, 32: instruction register.
REQ-013 Ports op (6), funct (6), rs (5), rt (5), rd (5), imm (16), output: instr[31:26], [5:0], [25:21], [20:16], [15:11], [15:0].
REQ-014 Port mdr, output, 32: memory data register. Port timeout_err, output, 1: sticky abort flag.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, BUSY, DONE.
REQ-016 In IDLE with access=1, the block SHALL capture the following, then go to BUSY:
  - addr = iord ? aluout : pc
  - we = memwrite
  - wdata = writedata
  - ircap = irwrite & ~memwrite
REQ-017 In IDLE with access=0, the block SHALL remain in IDLE and capture nothing.
REQ-018 In BUSY, mem_req SHALL be 1, and mem_addr, mem_we and mem_wdata SHALL hold the captured values stable.
REQ-019 BUSY with mem_ack=1 SHALL go to DONE, with these updates:
  - read (we=0): mdr <= mem_rdata
  - ircap=1: instr <= mem_rdata
  - write: no register update
REQ-020 The wait counter SHALL clear on entry to BUSY and increment for each BUSY cycle with mem_ack=0.
REQ-021 When the counter equals TIMEOUT with mem_ack=0, the block SHALL set timeout_err, go to DONE, and leave instr and mdr unchanged.
REQ-022 mem_ack arriving in the same cycle the counter reaches TIMEOUT SHALL complete normally, with no error.
REQ-023 DONE SHALL last exactly one cycle and then go to IDLE, ignoring access in that cycle.
REQ-024 stall SHALL be combinational and equal (state==IDLE & access) | (state==BUSY). stall SHALL be 0 in DONE.
REQ-025 Minimum latency: access asserted in cycle t with mem_ack in t+1 SHALL give stall=1 in t and t+1, and stall=0 in t+2.
REQ-026 mem_ack received outside BUSY SHALL be ignored.
REQ-027 mem_req SHALL be 0 in IDLE and DONE, giving at least one idle cycle between consecutive requests.
REQ-028 timeout_err SHALL remain set until reset.
REQ-029 The decoded field outputs SHALL be pure slices of instr, with no additional latency.

Reset
REQ-030 reset=1 SHALL force the following immediately, without waiting for a clock edge, including mid-transaction:
  - state = IDLE
  - mem_req, mem_we, mem_addr, mem_wdata = 0
  - instr, mdr, counter, timeout_err = 0
REQ-031 A transaction interrupted by reset SHALL NOT be replayed.
REQ-032 A mem_ack arriving after reset deassertion SHALL be ignored.

Structure
REQ-033 A shared package SHALL hold:
  - the state enum (IDLE, BUSY, DONE)
  - the TIMEOUT default
  - the instruction field bit-position constants, shared with the controller decoder
REQ-034 One sub-module, mem_wait_timer, SHALL contain the counter and compare. Its ports are clear, count, and expired.
REQ-035 All other logic SHALL reside in mem_fetch_unit.

Verification
REQ-036 Fetch scenario: pc=0x0000_0040, iord=0, irwrite=1, access=1, mem_ack in the 1st BUSY cycle, mem_rdata=0x8C43_0004. Required response:
  - mem_addr = 0x40
  - stall high for exactly 2 cycles
  - instr = 0x8C43_0004, op = 0x23, rs = 2, rt = 3, imm = 0x0004
REQ-037 Load scenario: aluout=0x0000_1004, iord=1, irwrite=0, mem_ack after 3 wait cycles, mem_rdata=0xDEAD_BEEF. Required response:
  - mem_req high for 4 cycles
  - mdr = 0xDEAD_BEEF
  - instr unchanged
REQ-038 Store scenario: memwrite=1, writedata=0x1234_5678, aluout=0x20. Required response:
  - mem_we = 1, mem_wdata = 0x1234_5678, mem_addr = 0x20 while BUSY
  - mdr and instr unchanged
REQ-039 Timeout scenario: TIMEOUT=4, no mem_ack. Required response:
  - timeout_err set after the 4th BUSY cycle
  - DONE for 1 cycle, then IDLE
  - mdr unchanged
  - timeout_err stays high across later transactions
REQ-040 Reset scenario: reset asserted in the 2nd BUSY cycle of a load, then mem_ack pulsed after deassertion. Required response:
  - mem_req = 0 immediately on reset
  - all outputs zero
  - the stray mem_ack is ignored and mdr stays 0
REQ-041 Back-to-back scenario: access held high across DONE. Required response:
  - exactly one transaction for that access
  - a new access in the following IDLE starts a second transaction
  - mem_req low for at least one cycle between the two transactions
